// File: rtl/seg7_bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaled tick, clear/load, wrap flag and a
// time-multiplexed 7-segment scan driver with optional leading-zero blanking.
module seg7_bcd_scan_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned SCAN_DIV = 2,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                up_i,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_val_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                wrap_o,
  output logic [DIGITS-1:0]   an_o,
  output logic [7:0]          seg_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TmrLast  = TW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                wrap_q, wrap_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                tick, carry, upper_zero;
  logic [3:0]          nib, nib_s;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'b11111100;
      4'd1:    seg_decode = 8'b01100000;
      4'd2:    seg_decode = 8'b11011010;
      4'd3:    seg_decode = 8'b11110010;
      4'd4:    seg_decode = 8'b01100110;
      4'd5:    seg_decode = 8'b10110110;
      4'd6:    seg_decode = 8'b10111110;
      4'd7:    seg_decode = 8'b11100000;
      4'd8:    seg_decode = 8'b11111110;
      4'd9:    seg_decode = 8'b11100110;
      default: seg_decode = 8'b00000000;
    endcase
  endfunction

  assign tick = en_i && (presc_q == PresLast);

  always_comb begin
    bcd_d   = bcd_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    carry   = 1'b0;
    nib     = 4'd0;
    if (clr_i) begin
      bcd_d   = '0;
      presc_d = '0;
    end else if (load_i) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        nib = load_val_i[4*i +: 4];
        bcd_d[4*i +: 4] = (nib > 4'd9) ? 4'd0 : nib;
      end
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
      // Ripple carry/borrow; it survives the last digit only on a full wrap.
      carry   = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
        nib = bcd_q[4*i +: 4];
        if (carry) begin
          if (up_i) begin
            if (nib == 4'd9) nib = 4'd0;
            else begin
              nib   = nib + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (nib == 4'd0) nib = 4'd9;
            else begin
              nib   = nib - 4'd1;
              carry = 1'b0;
            end
          end
        end
        bcd_d[4*i +: 4] = nib;
      end
      wrap_d = carry;
    end else if (en_i) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_comb begin
    tmr_d = tmr_q + 1'b1;
    idx_d = idx_q;
    if (tmr_q == TmrLast) begin
      tmr_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Walk from the top digit down so upper_zero covers digits i..DIGITS-1.
  always_comb begin
    an_d       = '0;
    seg_d      = 8'b00000000;
    upper_zero = 1'b1;
    nib_s      = 4'd0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nib_s      = bcd_q[4*i +: 4];
      upper_zero = upper_zero && (nib_s == 4'd0);
      if (idx_q == IW'(i)) begin
        an_d[i] = 1'b1;
        seg_d   = (BLANK_LZ && (i != 0) && upper_zero) ? 8'b00000000 : seg_decode(nib_s);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcd_q   <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      tmr_q   <= '0;
      idx_q   <= '0;
      an_q    <= DIGITS'(1);
      seg_q   <= 8'b11111100;
    end else begin
      bcd_q   <= bcd_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign wrap_o = wrap_q;
  assign an_o   = an_q;
  assign seg_o  = seg_q;

endmodule

// File: tb/tb_seg7_bcd_scan_counter.sv
// Bench for seg7_bcd_scan_counter: vector table, hand-written corner sequences and random
// stimulus, all checked against an arithmetic model of the counter and display scan.
module tb_seg7_bcd_scan_counter;
  localparam int D  = 4;
  localparam int TD = 4;
  localparam int SD = 2;
  localparam int N  = 10000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [15:0] load_val = 16'h0;
  logic [15:0] bcd_a, bcd_b;
  logic        wrap_a, wrap_b;
  logic [3:0]  an_a, an_b;
  logic [7:0]  seg_a, seg_b;

  int errors = 0;
  int checks = 0;

  int         m_val, m_pre, m_scan;
  logic       m_wrap;
  logic [3:0] m_an;
  logic [7:0] m_seg_a, m_seg_b;

  always #5 clk = ~clk;

  seg7_bcd_scan_counter #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
    .load_val_i(load_val), .bcd_o(bcd_a), .wrap_o(wrap_a), .an_o(an_a), .seg_o(seg_a)
  );

  seg7_bcd_scan_counter #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
    .load_val_i(load_val), .bcd_o(bcd_b), .wrap_o(wrap_b), .an_o(an_b), .seg_o(seg_b)
  );

  function automatic logic [7:0] dec(input int d);
    case (d)
      0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
      4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE0;
      8: return 8'hFE;  9: return 8'hE6;  default: return 8'h00;
    endcase
  endfunction

  function automatic int pow10(input int k);
    int r = 1;
    for (int j = 0; j < k; j++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int j = 0; j < D; j++) begin
      r[4*j +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] b);
    int r = 0;
    for (int j = D - 1; j >= 0; j--) begin
      int n = int'(b[4*j +: 4]);
      if (n > 9) n = 0;
      r = r * 10 + n;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_scan = 0; m_wrap = 1'b0;
    m_an = 4'b0001; m_seg_a = 8'hFC; m_seg_b = 8'hFC;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    int idx = (m_scan / SD) % D;
    int dig = (m_val / pow10(idx)) % 10;
    m_an    = 4'(1 << idx);
    m_seg_a = dec(dig);
    m_seg_b = (idx > 0 && m_val < pow10(idx)) ? 8'h00 : dec(dig);
    m_scan++;
    m_wrap = 1'b0;
    if (clr) begin
      m_val = 0; m_pre = 0;
    end else if (load) begin
      m_val = from_load(load_val); m_pre = 0;
    end else if (en) begin
      if (m_pre == TD - 1) begin
        m_pre  = 0;
        m_wrap = (up && m_val == N - 1) || (!up && m_val == 0);
        m_val  = up ? (m_val + 1) % N : (m_val + N - 1) % N;
      end else begin
        m_pre++;
      end
    end
  endtask

  task automatic compare_all();
    chk("bcd", 32'(bcd_a), 32'(to_bcd(m_val)));
    chk("wrap", 32'(wrap_a), 32'(m_wrap));
    chk("an", 32'(an_a), 32'(m_an));
    chk("seg", 32'(seg_a), 32'(m_seg_a));
    chk("bcd_blank", 32'(bcd_b), 32'(to_bcd(m_val)));
    chk("wrap_blank", 32'(wrap_b), 32'(m_wrap));
    chk("an_blank", 32'(an_b), 32'(m_an));
    chk("seg_blank", 32'(seg_b), 32'(m_seg_b));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [15:0] v);
    en = e; up = u; clr = c; load = l; load_val = v;
  endtask

  typedef struct {
    logic        en, up, clr, load;
    logic [15:0] val;
    int          cycles;
    logic [15:0] exp_bcd;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs [$];

  initial begin
    bit seen;
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3,  16'h0000, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1,  16'h0000, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 1,  16'h1234, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 16'h12A4, 1,  16'h1204, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1,  16'h9999, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4,  16'h0000, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4,  16'h9999, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1,  16'h0000, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 40, 16'h0010, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 10, 16'h0010, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 2,  16'h0010, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 10, 16'h0010, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 2,  16'h0011, 1'b0});

    // Reset held for three edges, then released away from the edge.
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    compare_all();
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("an_walk", 32'(an_a), 32'(1 << (((k - 1) / 2) % 4)));
    end

    foreach (vecs[r]) begin
      drive(vecs[r].en, vecs[r].up, vecs[r].clr, vecs[r].load, vecs[r].val);
      for (int c = 0; c < vecs[r].cycles; c++) step();
      chk("vec_bcd", 32'(bcd_a), 32'(vecs[r].exp_bcd));
      chk("vec_wrap", 32'(wrap_a), 32'(vecs[r].exp_wrap));
      if (r == 5 || r == 6) begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        step();
        chk("wrap_one_cycle", 32'(wrap_a), 32'd0);
      end
    end

    // bcd is 0x0011 here: digit 1 must show a "1" when its select is active.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (an_a == 4'b0010) begin
        seen = 1'b1;
        chk("digit1_seg", 32'(seg_a), 32'h60);
      end
    end
    chk("digit1_selected", 32'(seen), 32'd1);

    // Leading-zero blanking on 0x0050, then on 0.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0050);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    step();
    for (int c = 0; c < 8; c++) begin
      step();
      case (an_b)
        4'b0001: chk("blank50_d0", 32'(seg_b), 32'hFC);
        4'b0010: chk("blank50_d1", 32'(seg_b), 32'hB6);
        4'b0100: chk("blank50_d2", 32'(seg_b), 32'h00);
        4'b1000: chk("blank50_d3", 32'(seg_b), 32'h00);
        default: chk("blank50_an", 32'(an_b), 32'h1);
      endcase
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    step();
    for (int c = 0; c < 8; c++) begin
      step();
      chk("blank0", 32'(seg_b), (an_b == 4'b0001) ? 32'hFC : 32'h00);
    end

    // Randomised stimulus with loads biased toward the wrap boundaries.
    for (int c = 0; c < 500; c++) begin
      logic [15:0] v;
      case ($urandom % 4)
        0:       v = 16'h9999;
        1:       v = 16'h0000;
        2:       v = 16'h9998;
        default: v = 16'($urandom);
      endcase
      drive(($urandom % 4) != 0, ($urandom % 2) == 1, ($urandom % 60) == 0,
            ($urandom % 25) == 0, v);
      step();
    end

    // Asynchronous reset mid-count discards the pending prescale.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h4567);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
